// File: rtl/traffic_pkg.sv
// Shared colour encoding, fault codes and FSM states for the light conflict monitor.
// Light vectors are one-hot {green, yellow, red}.
package traffic_pkg;

  localparam int GREEN  = 2;
  localparam int YELLOW = 1;
  localparam int RED    = 0;

  localparam logic [2:0] RED_ONLY    = 3'b001;
  localparam logic [2:0] YELLOW_ONLY = 3'b010;
  localparam logic [2:0] GREEN_ONLY  = 3'b100;

  localparam logic [2:0] FC_NONE         = 3'd0;
  localparam logic [2:0] FC_ENCODING     = 3'd1;
  localparam logic [2:0] FC_CONFLICT     = 3'd2;
  localparam logic [2:0] FC_SEQUENCE     = 3'd3;
  localparam logic [2:0] FC_SHORT_YELLOW = 3'd4;
  localparam logic [2:0] FC_STUCK        = 3'd5;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  function automatic logic is_one_hot(input logic [2:0] v);
    return (v == RED_ONLY) || (v == YELLOW_ONLY) || (v == GREEN_ONLY);
  endfunction

endpackage

// File: rtl/light_seq_checker.sv
// Per-light checker: encoding, transition legality, yellow duration and stuck colour.
// Latency: error flags are combinational on the registered light; counters update on clk.
// Backpressure: none, evaluates every cycle.
module light_seq_checker
  import traffic_pkg::*;
#(
  parameter logic [31:0] STUCK_TICKS    = 32'd8,
  parameter logic [31:0] MIN_YELLOW_CYC = 32'd50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       init,
  input  logic [2:0] light_q,
  output logic       enc_err,
  output logic       seq_err,
  output logic       short_yel_err,
  output logic       stuck_err
);

  localparam logic [31:0] STUCK_SAT = STUCK_TICKS + 32'd1;

  logic [2:0]  prev_q;
  logic [31:0] stuck_cnt;
  logic [31:0] yel_cnt;
  logic        changed;
  logic        legal_step;

  assign changed    = (light_q != prev_q);
  assign legal_step = ((prev_q == RED_ONLY)    && (light_q == GREEN_ONLY))  ||
                      ((prev_q == GREEN_ONLY)  && (light_q == YELLOW_ONLY)) ||
                      ((prev_q == YELLOW_ONLY) && (light_q == RED_ONLY));

  assign enc_err       = !is_one_hot(light_q);
  assign seq_err       = changed && !legal_step;
  assign short_yel_err = (prev_q == YELLOW_ONLY) && (light_q == RED_ONLY) &&
                         (yel_cnt < MIN_YELLOW_CYC);
  assign stuck_err     = (stuck_cnt == STUCK_SAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= RED_ONLY;
      stuck_cnt <= '0;
      yel_cnt   <= '0;
    end else begin
      prev_q <= light_q;

      // A colour change on a tick cycle restarts the count rather than bumping it.
      if (init || changed)
        stuck_cnt <= '0;
      else if (tick && (stuck_cnt != STUCK_SAT))
        stuck_cnt <= stuck_cnt + 32'd1;

      // The first yellow cycle counts as one, so a yellow held N cycles reads N at the red edge.
      if (init)
        yel_cnt <= '0;
      else if (light_q[YELLOW]) begin
        if (!prev_q[YELLOW])
          yel_cnt <= 32'd1;
        else if (yel_cnt != MIN_YELLOW_CYC)
          yel_cnt <= yel_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/light_conflict_monitor.sv
// Safety gate between the light sequencer and the LED pins; latches a fault and flashes red.
// Latency: one cycle pass-through while monitoring; fault forcing one cycle after the bad sample.
// Backpressure: none, inputs are sampled every cycle.
module light_conflict_monitor
  import traffic_pkg::*;
#(
  parameter logic [31:0] TICK_MAX       = 32'd100000000,
  parameter logic [31:0] STUCK_TICKS    = 32'd8,
  parameter logic [31:0] MIN_YELLOW_CYC = 32'd50000000,
  parameter logic [31:0] FLASH_HALF     = 32'd50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] light1_in,
  input  logic [2:0] light2_in,
  input  logic       clear_fault,
  output logic [2:0] light1_out,
  output logic [2:0] light2_out,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash
);

  logic [2:0]  l1_q, l2_q;
  logic [31:0] tick_cnt;
  logic        tick;
  logic [31:0] flash_cnt;
  logic        flash_q;
  logic [2:0]  code_q;
  logic [2:0]  code_now;
  logic        in_init;
  state_t      state_q, state_d;

  logic enc1, seq1, short1, stuck1;
  logic enc2, seq2, short2, stuck2;

  assign tick    = (tick_cnt == TICK_MAX);
  assign in_init = (state_q == ST_INIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l1_q     <= RED_ONLY;
      l2_q     <= RED_ONLY;
      tick_cnt <= '0;
    end else begin
      l1_q     <= light1_in;
      l2_q     <= light2_in;
      tick_cnt <= tick ? 32'd0 : tick_cnt + 32'd1;
    end
  end

  light_seq_checker #(
    .STUCK_TICKS   (STUCK_TICKS),
    .MIN_YELLOW_CYC(MIN_YELLOW_CYC)
  ) u_chk1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .init         (in_init),
    .light_q      (l1_q),
    .enc_err      (enc1),
    .seq_err      (seq1),
    .short_yel_err(short1),
    .stuck_err    (stuck1)
  );

  light_seq_checker #(
    .STUCK_TICKS   (STUCK_TICKS),
    .MIN_YELLOW_CYC(MIN_YELLOW_CYC)
  ) u_chk2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .init         (in_init),
    .light_q      (l2_q),
    .enc_err      (enc2),
    .seq_err      (seq2),
    .short_yel_err(short2),
    .stuck_err    (stuck2)
  );

  // Lowest code wins when several checks fire together.
  always_comb begin
    code_now = FC_NONE;
    if (enc1 || enc2)
      code_now = FC_ENCODING;
    else if (!l1_q[RED] && !l2_q[RED])
      code_now = FC_CONFLICT;
    else if (seq1 || seq2)
      code_now = FC_SEQUENCE;
    else if (short1 || short2)
      code_now = FC_SHORT_YELLOW;
    else if (stuck1 || stuck2)
      code_now = FC_STUCK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_INIT;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    light1_out = RED_ONLY;
    light2_out = RED_ONLY;
    fault      = 1'b0;
    case (state_q)
      ST_INIT: state_d = ST_MONITOR;
      ST_MONITOR: begin
        light1_out = l1_q;
        light2_out = l2_q;
        if (code_now != FC_NONE)
          state_d = ST_FAULT;
      end
      ST_FAULT: begin
        light1_out = {2'b00, flash_q};
        light2_out = {2'b00, flash_q};
        fault      = 1'b1;
        if (clear_fault)
          state_d = ST_INIT;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Only the first cause is kept; the code is wiped as the FSM heads back to INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      code_q <= FC_NONE;
    else if ((state_q == ST_MONITOR) && (code_now != FC_NONE))
      code_q <= code_now;
    else if (state_d == ST_INIT)
      code_q <= FC_NONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_cnt <= '0;
      flash_q   <= 1'b0;
    end else if (state_d != ST_FAULT) begin
      flash_cnt <= '0;
      flash_q   <= 1'b0;
    end else if (state_q == ST_FAULT) begin
      if (flash_cnt == FLASH_HALF - 32'd1) begin
        flash_cnt <= '0;
        flash_q   <= ~flash_q;
      end else begin
        flash_cnt <= flash_cnt + 32'd1;
      end
    end
  end

  assign fault_code = code_q;
  assign flash      = flash_q;

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Directed scoreboard bench for light_conflict_monitor with small timing parameters.
module tb_light_conflict_monitor;

  typedef struct packed {
    logic [2:0] o1;
    logic [2:0] o2;
    logic       flt;
    logic [2:0] code;
    logic       fl;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] light1_in, light2_in;
  logic       clear_fault;
  logic [2:0] light1_out, light2_out;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash;

  obs_t  obs;
  obs_t  exp_q[$];
  string tag_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;

  logic [2:0] seq1 [6] = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b010, 3'b001};
  logic [2:0] seq2 [6] = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001};
  logic [2:0] pat5 [3] = '{3'b001, 3'b100, 3'b010};

  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b100;

  assign obs = {light1_out, light2_out, fault, fault_code, flash};

  light_conflict_monitor #(
    .TICK_MAX      (32'd3),
    .STUCK_TICKS   (32'd8),
    .MIN_YELLOW_CYC(32'd4),
    .FLASH_HALF    (32'd2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .light1_in  (light1_in),
    .light2_in  (light2_in),
    .clear_fault(clear_fault),
    .light1_out (light1_out),
    .light2_out (light2_out),
    .fault      (fault),
    .fault_code (fault_code),
    .flash      (flash)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [2:0] o1, input logic [2:0] o2,
                              input logic f, input logic [2:0] c, input logic fl);
    obs_t r;
    r.o1 = o1; r.o2 = o2; r.flt = f; r.code = c; r.fl = fl;
    return r;
  endfunction

  function automatic obs_t pass(input logic [2:0] a, input logic [2:0] b);
    return mk(a, b, 1'b0, 3'd0, 1'b0);
  endfunction

  function automatic obs_t flt(input logic [2:0] c, input logic fl);
    return mk({2'b00, fl}, {2'b00, fl}, 1'b1, c, fl);
  endfunction

  task automatic check(input obs_t e, input string tag);
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed o1=%b o2=%b fault=%b code=%0d flash=%b expected o1=%b o2=%b fault=%b code=%0d flash=%b",
             tag, obs.o1, obs.o2, obs.flt, obs.code, obs.fl, e.o1, e.o2, e.flt, e.code, e.fl);
    end
  endtask

  // Drive one cycle of stimulus, queue what must appear after the sampling edge, then compare.
  task automatic step(input logic [2:0] a, input logic [2:0] b, input logic clr,
                      input obs_t e, input string tag);
    obs_t  exp_e;
    string exp_t;
    light1_in   = a;
    light2_in   = b;
    clear_fault = clr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    cyc++;
    exp_e = exp_q.pop_front();
    exp_t = tag_q.pop_front();
    check(exp_e, exp_t);
  endtask

  initial begin
    int m;
    int first_inc;
    int e9;
    logic [2:0] p;

    rst_n       = 1'b0;
    light1_in   = R;
    light2_in   = R;
    clear_fault = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check(pass(R, R), "reset_state");
    rst_n = 1'b1;

    step(R, R, 1'b0, pass(R, R), "warmup");

    // Legal cycle, each colour pair held 4 cycles, three loops.
    for (int l = 0; l < 3; l++)
      for (int s = 0; s < 6; s++)
        for (int k = 0; k < 4; k++)
          step(seq1[s], seq2[s], 1'b0, pass(seq1[s], seq2[s]), "legal_pass");

    // Both green: conflict, then flashing with a 2-cycle half period.
    step(G, G, 1'b0, pass(G, G), "conflict_sample");
    step(R, R, 1'b0, flt(3'd2, 1'b0), "conflict_fault");
    step(R, R, 1'b0, flt(3'd2, 1'b0), "flash_low2");
    step(R, R, 1'b0, flt(3'd2, 1'b1), "flash_high1");
    step(R, R, 1'b0, flt(3'd2, 1'b1), "flash_high2");
    step(R, R, 1'b0, flt(3'd2, 1'b0), "flash_low_again");
    step(R, R, 1'b1, pass(R, R), "clear_to_init_a");
    step(R, R, 1'b0, pass(R, R), "monitor_after_clear_a");

    // Green straight to red, then a later conflict must not overwrite the code.
    step(G, R, 1'b0, pass(G, R), "seq_green");
    step(R, R, 1'b0, pass(R, R), "seq_skip_sample");
    step(G, G, 1'b0, flt(3'd3, 1'b0), "seq_fault");
    step(G, G, 1'b0, flt(3'd3, 1'b0), "seq_hold_a");
    step(G, G, 1'b0, flt(3'd3, 1'b1), "seq_code_kept");
    step(R, R, 1'b1, pass(R, R), "clear_to_init_b");
    step(R, R, 1'b0, pass(R, R), "monitor_after_clear_b");

    // Yellow held only 2 cycles.
    step(G, R, 1'b0, pass(G, R), "sy_green");
    step(Y, R, 1'b0, pass(Y, R), "sy_yellow1");
    step(Y, R, 1'b0, pass(Y, R), "sy_yellow2");
    step(R, R, 1'b0, pass(R, R), "sy_red_sample");
    step(R, R, 1'b0, flt(3'd4, 1'b0), "short_yellow_fault");
    step(R, R, 1'b1, pass(R, R), "clear_to_init_c");
    step(R, R, 1'b0, pass(R, R), "monitor_after_clear_c");

    // Bad encoding together with a conflict: encoding has priority.
    step(3'b110, G, 1'b0, pass(3'b110, G), "enc_sample");
    step(R, R, 1'b0, flt(3'd1, 1'b0), "enc_beats_conflict");
    step(R, R, 1'b1, pass(R, R), "clear_to_init_d");

    // Light2 stays red. Stuck counter clears on the INIT edge m+1, then bumps on every
    // edge e with e % 4 == 0 (tick counter started at reset). Ninth bump -> fault next edge.
    m         = cyc;
    first_inc = ((m + 2 + 3) / 4) * 4;
    e9        = first_inc + 32;
    for (int e = m + 1; e <= e9 + 1; e++) begin
      p = pat5[((e - m - 1) / 4) % 3];
      if (e == e9 + 1)
        step(p, R, 1'b0, flt(3'd5, 1'b0), "stuck_fault");
      else
        step(p, R, 1'b0, pass(p, R), "stuck_wait");
    end
    step(R, R, 1'b0, flt(3'd5, 1'b0), "stuck_flash_low");
    step(R, R, 1'b0, flt(3'd5, 1'b1), "stuck_flash_high");
    step(R, R, 1'b1, pass(R, R), "clear_to_init_e");
    step(R, R, 1'b0, pass(R, R), "monitor_after_clear_e");
    step(R, R, 1'b1, pass(R, R), "clear_ignored_in_monitor");

    // Fault again, then pull reset asynchronously while the flash is high.
    step(G, G, 1'b0, pass(G, G), "conflict2_sample");
    step(R, R, 1'b0, flt(3'd2, 1'b0), "conflict2_fault");
    step(R, R, 1'b0, flt(3'd2, 1'b0), "conflict2_low");
    step(R, R, 1'b0, flt(3'd2, 1'b1), "conflict2_high");
    #2;
    rst_n = 1'b0;
    #1;
    check(pass(R, R), "async_reset_mid_flash");
    #3;
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/light_conflict_monitor.md
Name: light_conflict_monitor

Overview:
Downstream safety stage between the two-way traffic light sequencer and the board LED pins. It consumes the two 3-bit light vectors and passes them through while they are legal. On any illegal pattern, illegal transition, short yellow or stuck light, it latches a fault code and forces both directions to flashing red until cleared.

Parameters:
TICK_MAX, 32'd100000000, tick period minus 1 in clk cycles; a tick pulse occurs when the tick counter equals TICK_MAX.
STUCK_TICKS, 32'd8, maximum whole ticks a light may hold one colour.
MIN_YELLOW_CYC, 32'd50000000, minimum clk cycles a yellow must be held.
FLASH_HALF, 32'd50000000, clk cycles per half-period of the fail-safe red flash.

Ports:
clk  input  1  system clock; all state is on posedge.
rst_n  input  1  asynchronous active-low reset.
light1_in  input  3  direction 1 from the sequencer; bit2 = green, bit1 = yellow, bit0 = red.
light2_in  input  3  direction 2; same encoding.
clear_fault  input  1  level, sampled on clk; leaves FAULT.
light1_out  output  3  to LEDs; same encoding.
light2_out  output  3  to LEDs; same encoding.
fault  output  1  high while in FAULT.
fault_code  output  3  latched cause; 0 = none.
flash  output  1  fail-safe flash phase.

Behaviour:
- Reset (async, rst_n = 0):
  - light1_out = light2_out = 3'b001; fault = 0; fault_code = 0; flash = 0.
  - All counters cleared; state = INIT.
- Inputs are registered once (l1_q, l2_q). All checks use the registered values.
  - Pass-through latency is 1 cycle: out(t+1) = in(t) in MONITOR.
- States:
  - INIT: outputs all-red. Loads the previous-value registers from l1_q/l2_q, with no sequence check. Goes to MONITOR next cycle.
  - MONITOR: outputs = l1_q/l2_q. Evaluates checks every cycle.
  - FAULT: light1_out = light2_out = {2'b00, flash}. flash toggles each FLASH_HALF cycles, starting 0 on entry.
- Fault codes, evaluated in MONITOR. If several fire in one cycle, the lowest code wins.
  - 1 ENCODING: either l*_q not exactly one-hot.
  - 2 CONFLICT: both l1_q[0] = 0 and l2_q[0] = 0.
  - 3 SEQUENCE: per light, a change other than red→green, green→yellow or yellow→red.
  - 4 SHORT_YELLOW: yellow→red when the yellow cycle count is < MIN_YELLOW_CYC.
  - 5 STUCK: a light's stuck counter reaches STUCK_TICKS+1.
- On a fault: next cycle state = FAULT, fault = 1, fault_code = code. The first forced output appears the same cycle fault rises.
- fault_code holds until clear; later faults do not overwrite it.
- FAULT exit: clear_fault = 1 → INIT next cycle. fault_code = 0 and fault = 0 in INIT.
  - clear_fault is ignored in INIT and MONITOR.
- Tick counter: free-running 0..TICK_MAX, then wraps to 0; tick pulses 1 cycle at TICK_MAX.
  - Runs in all states.
- Stuck counter (per light):
  - Cleared on a colour change or in INIT.
  - Otherwise increments on tick, saturating at STUCK_TICKS+1.
- Yellow counter (per light): counts cycles while yellow and saturates at MIN_YELLOW_CYC. It is cleared on entering yellow.
- Widths: all counters are 32-bit; comparisons are unsigned.
- A simultaneous tick and colour change clears the stuck counter (the change wins).
- Reset asserted mid-FAULT or mid-flash returns to all-red, no fault, immediately (async).

Decomposition:
- Package traffic_pkg:
  - colour bit indices: GREEN = 2, YELLOW = 1, RED = 0; localparam RED_ONLY = 3'b001.
  - fault code constants 0–5.
  - state encoding INIT/MONITOR/FAULT.
- Sub-module light_seq_checker, instantiated once per light:
  - holds prev colour, stuck counter and yellow counter.
  - outputs enc_err, seq_err, short_yel_err, stuck_err.
  - takes tick and init as inputs.
- The top holds the input registers, tick counter, priority encode, FSM and flash counter.

Test Plan:
(Bench parameters: TICK_MAX = 3, STUCK_TICKS = 8, MIN_YELLOW_CYC = 4, FLASH_HALF = 2.)
1. Legal sequence, each state held for 4 cycles: light1 001,001,001,100,010,001 with light2 100,010,001,001,001,001, repeated 3 loops → outputs mirror inputs 1 cycle late; fault stays 0.
2. Conflict: light1 = 100 while light2 = 100 → fault = 1, fault_code = 2 one cycle after the registered sample. Outputs flash 000/001 with a 2-cycle half-period.
3. Green→red skip on light1 (100 then 001) → fault_code = 3. A later conflict leaves fault_code at 3.
4. Yellow held for 2 cycles, then red → fault_code = 4. Enc error plus conflict in the same cycle (light1 = 110, light2 = 100) → fault_code = 1.
5. light2 held at 001 beyond 9 ticks (36 cycles) while light1 cycles legally → fault_code = 5.
6. In FAULT, pulse clear_fault → INIT outputs 001/001, then MONITOR; fault_code = 0. Drop rst_n mid-flash → immediate outputs 001/001, flash = 0.
